// File: rtl/matmul_engine.sv
// matmul_engine: computes C = A x B over a single-port data memory.
// Matrices are unsigned and row-major. The loop order is i (rows of A),
// then k (columns of B), then j (the inner product index, innermost).
// Optional build macro MATMUL_SAT_EN makes the accumulator saturate
// instead of wrapping. The overflow flag is set in both builds.
module matmul_engine #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8
) (
    input  logic              clock,
    input  logic              rst_r,
    input  logic              start,
    input  logic [DIM_W-1:0]  dim_x,
    input  logic [DIM_W-1:0]  dim_y,
    input  logic [DIM_W-1:0]  dim_z,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_c,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_wr_en,
    output logic [ACC_W-1:0]  mem_wr_data,
    input  logic              mem_stall,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ovf
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

    typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_B, S_MAC, S_WR, S_DONE} state_t;

    state_t state_q, state_d;
    logic [DIM_W-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
    logic [DIM_W-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
    logic [ADDR_W-1:0] base_b_q, base_b_d;
    logic [ADDR_W-1:0] a_row_q, a_row_d, a_ptr_q, a_ptr_d;
    logic [ADDR_W-1:0] b_col_q, b_col_d, b_ptr_q, b_ptr_d, c_ptr_q, c_ptr_d;
    logic [DATA_W-1:0] a_op_q, a_op_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              ovf_q, ovf_d, err_lat_q, err_lat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ACC_W-1:0]  wr_data_q, wr_data_d;
    logic              rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic [PROD_W-1:0] prod_s;
    logic [ACC_W:0]    mac_s;
    logic [ADDR_W-1:0] y_ext_s, z_ext_s;
    logic              last_term_s, last_col_s, last_row_s;

    // Accumulate one product; the MSB of the result flags a carry out of ACC_W.
    function automatic logic [ACC_W:0] mac_add(input logic [ACC_W-1:0] acc,
                                               input logic [PROD_W-1:0] prod);
        logic [SUM_W-1:0] sum;
        logic             carry;
        sum   = SUM_W'(acc) + SUM_W'(prod);
        carry = |sum[SUM_W-1:ACC_W];
`ifdef MATMUL_SAT_EN
        if (carry) begin
            mac_add = {1'b1, {ACC_W{1'b1}}};
        end else begin
            mac_add = {1'b0, sum[ACC_W-1:0]};
        end
`else
        mac_add = {carry, sum[ACC_W-1:0]};
`endif
    endfunction

    // Next-state, pointer/counter update and next-cycle output decode.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        base_b_d  = base_b_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        a_row_d   = a_row_q;
        a_ptr_d   = a_ptr_q;
        b_col_d   = b_col_q;
        b_ptr_d   = b_ptr_q;
        c_ptr_d   = c_ptr_q;
        a_op_d    = a_op_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        err_lat_d = err_lat_q;

        prod_s      = PROD_W'(a_op_q) * PROD_W'(mem_rd_data);
        mac_s       = mac_add(acc_q, prod_s);
        y_ext_s     = ADDR_W'(y_q);
        z_ext_s     = ADDR_W'(z_q);
        last_term_s = (j_q == (y_q - DIM_W'(1'b1)));
        last_col_s  = (k_q == (z_q - DIM_W'(1'b1)));
        last_row_s  = (i_q == (x_q - DIM_W'(1'b1)));

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d      = dim_x;
                    y_d      = dim_y;
                    z_d      = dim_z;
                    base_b_d = base_b;
                    ovf_d    = 1'b0;
                    i_d      = {DIM_W{1'b0}};
                    j_d      = {DIM_W{1'b0}};
                    k_d      = {DIM_W{1'b0}};
                    acc_d    = {ACC_W{1'b0}};
                    a_row_d  = base_a;
                    a_ptr_d  = base_a;
                    b_col_d  = base_b;
                    b_ptr_d  = base_b;
                    c_ptr_d  = base_c;
                    if ((dim_x == {DIM_W{1'b0}}) || (dim_y == {DIM_W{1'b0}}) ||
                        (dim_z == {DIM_W{1'b0}})) begin
                        err_lat_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        err_lat_d = 1'b0;
                        state_d   = S_RD_A;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_A: begin
                if (!mem_stall) begin
                    state_d = S_RD_B;
                end else begin
                    state_d = S_RD_A;
                end
            end
            S_RD_B: begin
                // A data arrived from the read accepted on entry to this state.
                if (!mem_stall) begin
                    a_op_d  = mem_rd_data;
                    state_d = S_MAC;
                end else begin
                    state_d = S_RD_B;
                end
            end
            S_MAC: begin
                acc_d = mac_s[ACC_W-1:0];
                if (mac_s[ACC_W]) begin
                    ovf_d = 1'b1;
                end else begin
                    ovf_d = ovf_q;
                end
                if (!last_term_s) begin
                    j_d     = j_q + DIM_W'(1'b1);
                    a_ptr_d = a_ptr_q + ADDR_W'(1'b1);
                    b_ptr_d = b_ptr_q + z_ext_s;
                    state_d = S_RD_A;
                end else begin
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (!mem_stall) begin
                    acc_d   = {ACC_W{1'b0}};
                    j_d     = {DIM_W{1'b0}};
                    c_ptr_d = c_ptr_q + ADDR_W'(1'b1);
                    if (!last_col_s) begin
                        // Next column of B, same row of A.
                        k_d     = k_q + DIM_W'(1'b1);
                        a_ptr_d = a_row_q;
                        b_col_d = b_col_q + ADDR_W'(1'b1);
                        b_ptr_d = b_col_q + ADDR_W'(1'b1);
                        state_d = S_RD_A;
                    end else if (!last_row_s) begin
                        // Next row of A, back to the first column of B.
                        k_d     = {DIM_W{1'b0}};
                        i_d     = i_q + DIM_W'(1'b1);
                        a_row_d = a_row_q + y_ext_s;
                        a_ptr_d = a_row_q + y_ext_s;
                        b_col_d = base_b_q;
                        b_ptr_d = base_b_q;
                        state_d = S_RD_A;
                    end else begin
                        k_d     = {DIM_W{1'b0}};
                        i_d     = {DIM_W{1'b0}};
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_WR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rd_en_d   = 1'b0;
        wr_en_d   = 1'b0;
        addr_d    = {ADDR_W{1'b0}};
        wr_data_d = {ACC_W{1'b0}};
        busy_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_d)
            S_RD_A: begin
                rd_en_d = 1'b1;
                addr_d  = a_ptr_d;
                busy_d  = 1'b1;
            end
            S_RD_B: begin
                rd_en_d = 1'b1;
                addr_d  = b_ptr_d;
                busy_d  = 1'b1;
            end
            S_MAC: begin
                busy_d = 1'b1;
            end
            S_WR: begin
                wr_en_d   = 1'b1;
                addr_d    = c_ptr_d;
                wr_data_d = acc_d;
                busy_d    = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
                err_d  = err_lat_d;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State, datapath and registered-output flops with asynchronous clear.
    always_ff @(posedge clock or negedge rst_r) begin
        if (!rst_r) begin
            state_q   <= S_IDLE;
            x_q       <= {DIM_W{1'b0}};
            y_q       <= {DIM_W{1'b0}};
            z_q       <= {DIM_W{1'b0}};
            i_q       <= {DIM_W{1'b0}};
            j_q       <= {DIM_W{1'b0}};
            k_q       <= {DIM_W{1'b0}};
            base_b_q  <= {ADDR_W{1'b0}};
            a_row_q   <= {ADDR_W{1'b0}};
            a_ptr_q   <= {ADDR_W{1'b0}};
            b_col_q   <= {ADDR_W{1'b0}};
            b_ptr_q   <= {ADDR_W{1'b0}};
            c_ptr_q   <= {ADDR_W{1'b0}};
            a_op_q    <= {DATA_W{1'b0}};
            acc_q     <= {ACC_W{1'b0}};
            ovf_q     <= 1'b0;
            err_lat_q <= 1'b0;
            addr_q    <= {ADDR_W{1'b0}};
            wr_data_q <= {ACC_W{1'b0}};
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            base_b_q  <= base_b_d;
            a_row_q   <= a_row_d;
            a_ptr_q   <= a_ptr_d;
            b_col_q   <= b_col_d;
            b_ptr_q   <= b_ptr_d;
            c_ptr_q   <= c_ptr_d;
            a_op_q    <= a_op_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            err_lat_q <= err_lat_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign mem_addr    = addr_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_data = wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign ovf         = ovf_q;

endmodule

// File: doc/matmul_engine.md
# matmul_engine

Parametrised matrix-multiply sequencer that computes C = A × B over a single-port data memory and runs without the instruction stream. It replaces the microcoded X/Y/Z, STXY/STYZ/STXZ and AC loop of the processor with a dedicated FSM and multiply-accumulate datapath. Matrix dimensions and base addresses are set at run time, and data, accumulator and address widths are set by parameters. It connects to the processor memory port and is started by a one-cycle strobe.

## Interface
- DATA_W, 8, element width of A and B (unsigned)
- ACC_W, 24, accumulator and C-element width
- ADDR_W, 16, memory address width
- DIM_W, 8, width of each dimension input
- clock  in  1  rising-edge clock
- rst_r  in  1  asynchronous, active-low reset
- start  in  1  one-cycle start strobe, honoured only in IDLE
- dim_x, dim_y, dim_z  in  DIM_W each  A is X×Y, B is Y×Z, C is X×Z
- base_a, base_b, base_c  in  ADDR_W each  row-major base addresses
- mem_addr  out  ADDR_W  memory address
- mem_rd_en  out  1  read request
- mem_rd_data  in  DATA_W  read data
- mem_wr_en  out  1  write request
- mem_wr_data  out  ACC_W  C element being written
- mem_stall  in  1  memory not ready; the request is not accepted
- busy  out  1  high from the cycle after start until DONE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, coincident with done, when any dimension is 0
- ovf  out  1  sticky accumulator-overflow flag, cleared by start

## Operation
- Reset: state IDLE. All outputs are 0. Counters, pointers and the accumulator are cleared.
- IDLE: when start=1, latch the dimensions and bases and clear ovf.
  - If any dimension is 0, go to DONE with err=1.
  - Otherwise go to RD_A. Loop counters i, k, j start at 0.
- Loop order: i over X, then k over Z, then j over Y (j innermost).
- Element addresses, all modulo 2^ADDR_W:
  - A[i][j] = base_a + i·Y + j
  - B[j][k] = base_b + j·Z + k
  - C[i][k] = base_c + i·Z + k
- Addresses come from running pointers using adders only:
  - A pointer: +1 per term, and rewinds to the row start when k advances.
  - B pointer: +Z per term, and resets to base_b + k when j wraps.
- RD_A: issue a read of A[i][j].
- RD_B: issue a read of B[j][k]. Capture mem_rd_data into the a-operand register.
- MAC: capture mem_rd_data as the b-operand and add a·b (2·DATA_W bits, zero-extended) to the accumulator.
  - If j < Y−1: increment j and go to RD_A.
  - If j = Y−1: go to WR.
- WR: drive mem_wr_en=1 with the C address and mem_wr_data = accumulator.
  - When the write is accepted: clear the accumulator and j, advance k (and i when k wraps).
  - Go to RD_A, or to DONE after the last element.
- DONE: done=1 (err as latched) for one cycle, then IDLE.
- start while not in IDLE is ignored.
- The accumulator wraps modulo 2^ACC_W, unless the saturation feature is compiled in (see Configuration).

## Timing
- A request is accepted on an edge where it is asserted and mem_stall=0.
- While mem_stall=1, the FSM, counters and mem_addr/mem_wr_data hold their values, and the request stays asserted.
- mem_rd_data is valid in the cycle after an accepted read. Memory holds it until the next accepted read.
- The MAC state samples mem_rd_data regardless of mem_stall.
- Without stalls:
  - 3 cycles per term and 1 per write.
  - DONE is reached X·Z·(3Y+1) cycles after the RD_A entry edge.
  - busy falls in the DONE cycle.
- Zero-dimension start: DONE is entered on the edge after start, and err and done pulse together.
- Asynchronous reset mid-run aborts immediately to IDLE with the reset values. No further writes occur, and memory contents are left as they are.
- mem_rd_en and mem_wr_en are never both high.

## Configuration
- MATMUL_SAT_EN defined:
  - An accumulate that exceeds 2^ACC_W−1 clamps to 2^ACC_W−1 and sets ovf.
  - The accumulator stays clamped for the rest of that C element.
- MATMUL_SAT_EN undefined:
  - The accumulator wraps modulo 2^ACC_W.
  - ovf is still set on carry-out, so the flag is always meaningful.

## Test plan
- X=Y=Z=2, A=[1,2;3,4] at 0x0000, B=[5,6;7,8] at 0x0010, base_c=0x0020 -> writes 19, 22, 43, 50 to 0x20..0x23 in that order; done asserted 28 cycles after RD_A entry; ovf=0.
- dim_y=0 with start -> no memory request at all; done=err=1 for one cycle on the next edge; busy stays 0.
- Same 2×2 run with mem_stall held high for 3 cycles during the 2nd RD_B and for 2 cycles during the 1st WR -> identical results; done delayed by exactly 5 cycles; address and data stable throughout the stalls.
- ACC_W=16, X=1, Y=2, Z=1, A=[255,255], B=[255;255] -> 64514 written and ovf=1 without MATMUL_SAT_EN; 65535 written and ovf=1 with it.
- 3×3×3 run: drop rst_r low after 10 cycles, then release it -> all outputs 0 immediately; after release the block sits in IDLE; a fresh start gives correct results.
- A second start pulse mid-run -> ignored; results and done timing match a run without it.
